clk_div_ctrl: RTL and testbench

Programmable clock-divide controller that owns the divider counter and schedules divide-ratio changes so the divided output never glitches. Software or a higher-level sequencer configures the block through a valid/ready port with a ratio, or a stop request. The block applies each change only on a period boundary. It produces a divided square wave plus a one-cycle tick per period, and all outputs are synchronous to `clk` for downstream clock-enable use.

---
 rtl/clk_div_pkg.sv | 5 +
 rtl/clk_div_if.sv | 16 +
 rtl/clk_div_period_counter.sv | 21 ++
 rtl/clk_div_ctrl.sv | 98 +++++++++
 tb/tb_clk_div_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the glitch-free programmable clock divider.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} div_state_t;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/clk_div_if.sv
// Config handshake and divided-clock outputs of clk_div_ctrl.
interface clk_div_if #(parameter int CNT_W = 8);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_stop;
  logic             div_out;
  logic             tick;
  logic             busy;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_div, cfg_stop,
                  input  cfg_ready, div_out, tick, busy, cfg_err);
  modport slave  (input  cfg_valid, cfg_div, cfg_stop,
                  output cfg_ready, div_out, tick, busy, cfg_err);
endinterface

// File: rtl/clk_div_period_counter.sv
// Period counter: counts 0..cur_div-1 while enabled, held at 0 otherwise.
module div_period_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] cur_div,
  output logic [CNT_W-1:0] next_cnt,
  output logic             last
);
  logic [CNT_W-1:0] cnt;

  assign last     = en && (cnt == cur_div - CNT_W'(1));
  assign next_cnt = (load || !en || last) ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) cnt <= '0;
    else       cnt <= next_cnt;
endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: config handshake, boundary-scheduled ratio changes and
// registered div_out/tick/cfg_err outputs.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      nrst,
  clk_div_if.slave  bus
);
  div_state_t       state, state_n;
  logic [CNT_W-1:0] cur_div, div_n, nxt_div, nxt_div_n, next_cnt;
  logic [CNT_W:0]   half_n;
  logic             nxt_stop, nxt_stop_n;
  logic             load, last, err_n, accept, illegal, run_n;

  assign bus.cfg_ready = (state != PEND);
  assign bus.busy      = (state != IDLE);
  assign accept        = bus.cfg_valid && bus.cfg_ready;
  assign illegal       = !bus.cfg_stop && (bus.cfg_div < CNT_W'(MIN_DIV));

  div_period_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .nrst     (nrst),
    .en       (state != IDLE),
    .load     (load),
    .cur_div  (cur_div),
    .next_cnt (next_cnt),
    .last     (last)
  );

  // Changes only take effect on the edge that ends a period (last).
  always_comb begin
    state_n    = state;
    div_n      = cur_div;
    nxt_div_n  = nxt_div;
    nxt_stop_n = nxt_stop;
    load       = 1'b0;
    err_n      = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (illegal) err_n = 1'b1;
        else if (!bus.cfg_stop) begin
          div_n   = bus.cfg_div;
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: if (accept) begin
        if (illegal) err_n = 1'b1;
        else if (last) begin
          if (bus.cfg_stop) state_n = IDLE;
          else begin
            div_n = bus.cfg_div;
            load  = 1'b1;
          end
        end else begin
          nxt_div_n  = bus.cfg_div;
          nxt_stop_n = bus.cfg_stop;
          state_n    = PEND;
        end
      end
      PEND: if (last) begin
        if (nxt_stop) state_n = IDLE;
        else begin
          div_n   = nxt_div;
          load    = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs look one cycle ahead using the counter value and ratio of the next cycle.
  assign run_n  = (state_n != IDLE);
  assign half_n = ({1'b0, div_n} + (CNT_W+1)'(1)) >> 1;

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state       <= IDLE;
      cur_div     <= CNT_W'(MIN_DIV);
      nxt_div     <= '0;
      nxt_stop    <= 1'b0;
      bus.div_out <= 1'b0;
      bus.tick    <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      state       <= state_n;
      cur_div     <= div_n;
      nxt_div     <= nxt_div_n;
      nxt_stop    <= nxt_stop_n;
      bus.div_out <= run_n && ({1'b0, next_cnt} < half_n);
      bus.tick    <= run_n && (next_cnt == div_n - CNT_W'(1));
      bus.cfg_err <= err_n;
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl against a period-pattern reference model.
module tb_clk_div_ctrl;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  int   total = 0;
  int   bad = 0;

  clk_div_if #(.CNT_W(8)) bus ();
  clk_div_ctrl #(.CNT_W(8)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  always #5 clk = ~clk;

  // Model: each running period is a queued list of {div_out,tick} samples.
  logic [1:0] q[$];
  logic [1:0] m_cur;
  bit         m_run, m_pend, m_pstop, m_err;
  int         m_n, m_pn;

  function automatic void load_period(int n);
    for (int i = 0; i < n; i++) begin
      logic hi, tk;
      hi = (i < (n + 1) / 2);
      tk = (i == n - 1);
      q.push_back({hi, tk});
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_cur = 2'b00; m_run = 0; m_pend = 0; m_pstop = 0; m_err = 0;
    m_n = 2; m_pn = 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit acc, legal, bnd, have, rstop;
    int rn;
    @(posedge clk);
    acc   = bus.cfg_valid && !m_pend;
    legal = bus.cfg_stop || (bus.cfg_div >= 2);
    m_err = acc && !legal;
    have = 0; rstop = 0; rn = 0;
    if (!m_run) begin
      m_cur = 2'b00;
      if (acc && legal && !bus.cfg_stop) begin
        m_run = 1; m_n = bus.cfg_div;
        load_period(m_n);
        m_cur = q.pop_front();
      end
    end else begin
      bnd = (q.size() == 0);
      if (m_pend) begin
        have = 1; rstop = m_pstop; rn = m_pn;
      end else if (acc && legal) begin
        if (bnd) begin
          have = 1; rstop = bus.cfg_stop; rn = bus.cfg_div;
        end else begin
          m_pend = 1; m_pstop = bus.cfg_stop; m_pn = bus.cfg_div;
        end
      end
      if (bnd) begin
        m_pend = 0;
        if (have && rstop) begin
          m_run = 0; m_cur = 2'b00;
        end else begin
          if (have) m_n = rn;
          load_period(m_n);
          m_cur = q.pop_front();
        end
      end else m_cur = q.pop_front();
    end
    #1;
    chk("div_out",   bus.div_out,   m_cur[1]);
    chk("tick",      bus.tick,      m_cur[0]);
    chk("busy",      bus.busy,      m_run);
    chk("cfg_ready", bus.cfg_ready, !m_pend);
    chk("cfg_err",   bus.cfg_err,   m_err);
  endtask

  task automatic idle(int n);
    bus.cfg_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(int d, bit s);
    bit acc;
    logic [31:0] dv;
    dv = d;
    bus.cfg_valid = 1'b1; bus.cfg_div = dv[7:0]; bus.cfg_stop = s;
    acc = 0;
    for (int k = 0; k < 600 && !acc; k++) begin
      acc = !m_pend;
      step();
    end
    bus.cfg_valid = 1'b0;
    if (!acc) begin
      bad++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
  endtask

  // Advance until the current cycle is the last of a period.
  task automatic to_boundary();
    bus.cfg_valid = 1'b0;
    for (int k = 0; k < 600 && !(m_run && m_cur[0]); k++) step();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_div_out"},   bus.div_out,   0);
    chk({tag, "_tick"},      bus.tick,      0);
    chk({tag, "_busy"},      bus.busy,      0);
    chk({tag, "_cfg_err"},   bus.cfg_err,   0);
    chk({tag, "_cfg_ready"}, bus.cfg_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_div = '0; bus.cfg_stop = 1'b0;
    model_reset();
    #2 nrst = 1'b0;
    #1 check_reset_outputs("reset");
    #19 nrst = 1'b1;
    idle(2);

    // N=3 from idle: 1,1,0 with tick on third cycle
    send(3, 0);
    idle(7);
    // N=4 then N=5 mid-period
    to_boundary(); send(4, 0);
    idle(1);
    send(5, 0);
    idle(12);
    // N=2 then N=6 exactly on the boundary
    to_boundary(); send(2, 0);
    to_boundary(); send(6, 0);
    idle(8);
    // illegal N=1 while running at N=4
    to_boundary(); send(4, 0);
    idle(1);
    send(1, 0);
    send(0, 0);
    idle(9);
    // stop mid-period at N=3, then restart at N=2
    to_boundary(); send(3, 0);
    send(0, 1);
    idle(5);
    send(2, 0);
    idle(4);
    // stop on the boundary, stop while idle, illegal while idle
    to_boundary(); send(0, 1);
    send(0, 1);
    send(1, 0);
    idle(2);
    // extreme ratios
    send(255, 0);
    to_boundary(); send(2, 0);
    idle(4);
    // reset while a change is pending
    to_boundary(); send(4, 0);
    idle(1);
    send(7, 0);
    #2 nrst = 1'b0;
    model_reset();
    #1 check_reset_outputs("pend_rst");
    #2 nrst = 1'b1;
    idle(12);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)      idle($urandom_range(1, 5));
      else if (r < 4) send(0, 1);
      else            send($urandom_range(0, 12), 0);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
